// File: rtl/alu_addsub_stage.sv
// alu_addsub_stage: two-stage add/sub front-end around an external adder; ADD_SAT_EN enables signed saturation
module alu_addsub_stage #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_op,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         flag_clr,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  output logic         add_cin,
  input  logic [W-1:0] add_sum,
  input  logic         add_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic [3:0]   out_flags,
  output logic         carry_q
);
  typedef enum logic [2:0] {
    OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CMP, OP_PASSA, OP_INC, OP_DEC
  } op_e;

  op_e          s1_op_q, s1_op_d;
  logic [W-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic         s1_valid_q, s1_valid_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_result_q, out_result_d;
  logic [3:0]   out_flags_q, out_flags_d;
  logic         carry_d;
  logic         adv, accept;
  logic [W-1:0] eff_b, res_pre;
  logic         eff_cin, c_flag, v_flag;

  assign adv      = s1_valid_q & (~out_valid_q | out_ready);
  assign in_ready = ~s1_valid_q | adv;
  assign accept   = in_valid & in_ready;

  // effective adder operand and carry-in for the op held in stage 1
  always_comb begin
    eff_b   = '0;
    eff_cin = 1'b0;
    case (s1_op_q)
      OP_ADD:         eff_b = s1_b_q;
      OP_ADC:         begin eff_b = s1_b_q;  eff_cin = carry_q; end
      OP_SUB, OP_CMP: begin eff_b = ~s1_b_q; eff_cin = 1'b1;    end
      OP_SBC:         begin eff_b = ~s1_b_q; eff_cin = carry_q; end
      OP_INC:         eff_cin = 1'b1;
      OP_DEC:         eff_b = '1;
      default:        ;
    endcase
  end

  // idle stage 1 parks the adder inputs at zero
  assign add_a   = s1_valid_q ? s1_a_q : '0;
  assign add_b   = s1_valid_q ? eff_b : '0;
  assign add_cin = s1_valid_q & eff_cin;

  assign c_flag = (s1_op_q != OP_PASSA) & add_cout;
  assign v_flag = (s1_op_q != OP_PASSA) & (add_a[W-1] == add_b[W-1]) & (add_sum[W-1] != add_a[W-1]);

`ifdef ADD_SAT_EN
  logic sat;
  // only the four add/sub ops (op[2]=0) clamp on signed overflow
  assign sat     = v_flag & ~s1_op_q[2];
  assign res_pre = sat ? {s1_a_q[W-1], {(W-1){~s1_a_q[W-1]}}} : add_sum;
`else
  assign res_pre = add_sum;
`endif

  // next-state for both pipeline stages and the persistent carry
  always_comb begin
    s1_valid_d   = accept | (s1_valid_q & ~adv);
    s1_op_d      = accept ? op_e'(in_op) : s1_op_q;
    s1_a_d       = accept ? in_a : s1_a_q;
    s1_b_d       = accept ? in_b : s1_b_q;
    out_valid_d  = adv ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    out_result_d = adv ? ((s1_op_q == OP_CMP) ? '0 : res_pre) : out_result_q;
    out_flags_d  = adv ? {res_pre[W-1], res_pre == '0, c_flag, v_flag} : out_flags_q;
    carry_d      = adv ? c_flag : (flag_clr ? 1'b0 : carry_q);
  end

  // pipeline registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_op_q      <= OP_ADD;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
      carry_q      <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_op_q      <= s1_op_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_flags_q  <= out_flags_d;
      carry_q      <= carry_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;
endmodule

// File: tb/tb_alu_addsub_stage.sv
// tb_alu_addsub_stage: randomized and directed checks of alu_addsub_stage against an arithmetic reference model
module tb_alu_addsub_stage;
  logic        clk = 0, rst_n = 0, in_valid = 0, flag_clr = 0, out_ready = 0;
  logic [2:0]  in_op = 0;
  logic [15:0] in_a = 0, in_b = 0;
  logic        in_ready, add_cin, add_cout, out_valid, carry_q;
  logic [15:0] add_a, add_b, add_sum, out_result;
  logic [3:0]  out_flags;

  alu_addsub_stage #(.W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .flag_clr(flag_clr), .add_a(add_a), .add_b(add_b),
    .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags), .carry_q(carry_q)
  );

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

  always #5 clk = ~clk;

  typedef struct { logic [15:0] r; logic [3:0] f; } exp_t;
  exp_t q[$];
  logic mcarry = 0;
  int n_vec = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference: unsigned/signed integer arithmetic straight from the op definitions
  function automatic void ref_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, output logic [15:0] r, output logic [3:0] f,
                                 output logic c);
    int ua = a, ub = b, sa = $signed(a), sb = $signed(b), ci = cin, u, s;
    logic v;
    logic [15:0] res;
    case (op)
      3'd0: begin u = ua + ub;            s = sa + sb;            c = u > 65535; end
      3'd1: begin u = ua + ub + ci;       s = sa + sb + ci;       c = u > 65535; end
      3'd2, 3'd4: begin u = ua - ub;      s = sa - sb;            c = u >= 0;    end
      3'd3: begin u = ua - ub - (1 - ci); s = sa - sb - (1 - ci); c = u >= 0;    end
      3'd5: begin u = ua;                 s = sa;                 c = 0;         end
      3'd6: begin u = ua + 1;             s = sa + 1;             c = u > 65535; end
      default: begin u = ua - 1;          s = sa - 1;             c = u >= 0;    end
    endcase
    v = (s > 32767) || (s < -32768);
    res = u[15:0];
`ifdef ADD_SAT_EN
    if (v && op < 3'd4) res = a[15] ? 16'h8000 : 16'h7FFF;
`endif
    f = {res[15], res == 16'h0, c, v};
    r = (op == 3'd4) ? 16'h0 : res;
  endfunction

  function automatic void push(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    logic c;
    ref_op(op, a, b, mcarry, e.r, e.f, c);
    mcarry = c;
    q.push_back(e);
  endfunction

  function automatic logic [15:0] rnd();
    logic [15:0] k[4] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};
    int s = $urandom_range(0, 7);
    return s < 4 ? k[s] : 16'($urandom);
  endfunction

  // one clock: drive just after posedge, observe ready at negedge, record acceptance at posedge
  task automatic cycle(input bit v, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input bit ordy, output bit acc);
    in_valid = v; in_op = op; in_a = a; in_b = b; out_ready = ordy;
    @(negedge clk);
    acc = v && in_ready;
    @(posedge clk);
    if (acc) push(op, a, b);
    #1;
    in_valid = 0;
  endtask

  task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] er, input logic [3:0] ef);
    logic [15:0] r;
    logic [3:0] f;
    logic c;
    bit acc = 0;
    ref_op(op, a, b, mcarry, r, f, c);
    chk("model_result", r, er);
    chk("model_flags", f, ef);
    for (int i = 0; i < 20 && !acc; i++) cycle(1, op, a, b, 1, acc);
    if (!acc) chk("accept_timeout", acc, 1);
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 50 && q.size() != 0; i++) cycle(0, 0, 0, 0, 1, acc);
    chk("drain_timeout", q.size(), 0);
  endtask

  // scoreboard: every cycle the head expectation must be on the outputs while out_valid is high
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", in_ready, !(q.size() == 2 && !out_ready));
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_out_valid", out_valid, 0);
        else begin
          chk("result", out_result, q[0].r);
          chk("flags", out_flags, q[0].f);
          chk("carry_q", carry_q, q[0].f[1]);
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    bit acc, have;
    int k;
    logic [2:0] pop;
    logic [15:0] pa, pb;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_carry", carry_q, 0);
    chk("rst_result", out_result, 0);
    chk("rst_flags", out_flags, 0);
    rst_n = 1;

    // overflow with output latency
`ifdef ADD_SAT_EN
    send(3'd0, 16'h7FFF, 16'h0001, 16'h7FFF, 4'b0001);
`else
    send(3'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001);
`endif
    chk("latency_cycle1", out_valid, 0);
    cycle(0, 0, 0, 0, 1, acc);
    chk("latency_cycle2", out_valid, 1);
    drain();

    send(3'd2, 16'h0005, 16'h0005, 16'h0000, 4'b0110);
    send(3'd1, 16'hFFFF, 16'h0000, 16'h0000, 4'b0110);
    send(3'd4, 16'h0003, 16'h0004, 16'h0000, 4'b1000);
    send(3'd7, 16'h0000, 16'h0000, 16'hFFFF, 4'b1000);
    send(3'd6, 16'hFFFF, 16'h0000, 16'h0000, 4'b0110);
    drain();

    // clear on an idle cycle, then SBC sees carry 0
    chk("carry_before_clr", carry_q, 1);
    flag_clr = 1;
    cycle(0, 0, 0, 0, 1, acc);
    flag_clr = 0;
    mcarry = 0;
    chk("flag_clr_idle", carry_q, 0);
    send(3'd3, 16'h0005, 16'h0002, 16'h0002, 4'b0010);
    drain();

    // clear coinciding with an advance loses to the new carry
    send(3'd7, 16'h0000, 16'h0000, 16'hFFFF, 4'b1000);
    drain();
    in_valid = 1; in_op = 3'd6; in_a = 16'hFFFF; in_b = 0; out_ready = 1;
    @(posedge clk);
    push(3'd6, 16'hFFFF, 16'h0000);
    #1;
    in_valid = 0;
    flag_clr = 1;
    @(posedge clk);
    #1;
    flag_clr = 0;
    chk("flag_clr_vs_adv", carry_q, 1);
    drain();

    // back-pressure: three offered, two held
    k = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1, 3'd0, 16'(k), 16'h0010, 0, acc);
      if (acc) k++;
    end
    chk("stall_accepted", k, 2);
    chk("stall_in_ready", in_ready, 0);
    for (int i = 0; i < 20 && k < 3; i++) begin
      cycle(1, 3'd0, 16'(k), 16'h0010, 1, acc);
      if (acc) k++;
    end
    chk("stall_release", k, 3);
    drain();

    // randomized traffic with random back-pressure
    have = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!have && $urandom_range(0, 3) != 0) begin
        pop = 3'($urandom); pa = rnd(); pb = rnd(); have = 1;
      end
      cycle(have, pop, pa, pb, $urandom_range(0, 3) != 0, acc);
      if (acc) have = 0;
      if (i % 300 == 299) begin
        drain();
        flag_clr = 1;
        cycle(0, 0, 0, 0, 1, acc);
        flag_clr = 0;
        mcarry = 0;
        chk("flag_clr_rand", carry_q, 0);
      end
    end
    drain();

    // reset while ops are in flight
    cycle(1, 3'd6, 16'hFFFF, 0, 0, acc);
    cycle(1, 3'd0, 16'h1234, 16'h1111, 0, acc);
    rst_n = 0;
    @(posedge clk);
    #1;
    q.delete();
    mcarry = 0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_carry", carry_q, 0);
    rst_n = 1;
    send(3'd1, 16'h0001, 16'h0001, 16'h0002, 4'b0000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
